hififo_read_scheduler: RTL and testbench
========================================

// Module: hififo_read_scheduler
// PURPOSE
//  Sequences DMA read requests for host-to-FPGA FIFO channels. Takes page-table entries
//  (addr, count, interrupt) from hififo_request, one descriptor slot per channel, and issues
//  PCIe memory-read requests: chunks of at most MRRS_W words that never cross a 4 KB boundary.
//  Round-robin arbitration between channels; tags allocated from a shared pool. Sits between
//  hififo_request and the TLP transmit unit.
// PARAMETERS
//  ENABLES  8'b00010001  channel i served only if ENABLES[i]=1; others: r_ready[i]=0, never granted
//  MRRS_W   64           max words (8 B) per request; power of two, 1..64
//  NTAGS    32           outstanding read tags; 1..32
// PORTS
//  clock        in   1   sole clock
//  reset        in   1   synchronous, active-low (0 = reset)
//  r_valid      in   8   one-cycle pulse: descriptor for channel i on r_addr/r_count/r_interrupt
//  r_addr       in   61  descriptor start address, 8-byte units
//  r_count      in   19  descriptor length, 8-byte words
//  r_interrupt  in   1   raise irq when descriptor fully issued
//  r_ready      out  8   channel i slot empty; accepts a descriptor
//  rq_valid     out  1   read request valid
//  rq_ready     in   1   TLP unit accepts request (rq_valid & rq_ready)
//  rq_addr      out  61  request address, 8-byte units
//  rq_len       out  7   request length in words, 1..MRRS_W
//  rq_tag       out  5   allocated tag
//  rq_ch        out  3   requesting channel
//  tag_release  in   1   completion for tag_rel_id fully received; tag returns to pool
//  tag_rel_id   in   5   tag being released
//  irq_valid    out  1   one-cycle pulse: descriptor with interrupt flag finished issuing
//  irq_ch       out  3   channel of that descriptor
// BEHAVIOUR
//  - Reset (reset=0 at clock edge): all slots empty, all NTAGS free, RR pointer=0, state ARB;
//    rq_valid=0, irq_valid=0, r_ready=ENABLES, rq_addr/len/tag/ch=0. Reset mid-request drops
//    rq_valid next cycle; partially issued descriptors are discarded.
//  - Slots: r_ready[i] = enabled & slot empty (registered). r_valid[i] with slot full or channel
//    disabled is ignored. Descriptor with r_count=0 loads, completes next cycle with no request;
//    irq_valid pulses if r_interrupt.
//  - FSM ARB: if any tag free and any slot busy with count>0, grant the first busy channel at or
//    after RR pointer (wraps 7->0); register rq_* and move to ISSUE. Else stay in ARB.
//  - rq_len = min(count, MRRS_W, 512 - addr[8:0]); the 4 KB rule uses the address LSBs
//    (512 words = 4 KB). rq_tag = lowest-numbered free tag, marked busy in the same cycle as grant.
//  - ISSUE: rq_valid=1; all rq_* held stable until rq_ready. On accept: slot addr += len,
//    count -= len, RR pointer = granted channel + 1, state -> ARB. Max throughput 1 req / 2 cycles.
//  - When count reaches 0 on accept: slot empties (r_ready rises next cycle); if interrupt flag,
//    irq_valid=1 for one cycle, irq_ch=channel, same cycle as r_ready rises.
//  - tag_release frees tag_rel_id next cycle; releasing a free tag is ignored. Release and grant
//    in the same cycle: released tag is not eligible until the following cycle.
//  - No free tags: remain in ARB and issue nothing; slots stay busy.
//  - r_valid on a channel while it is being granted is impossible (slot busy) and ignored.
//  - Arithmetic: addr 61-bit wraps mod 2^61; count 19-bit, never underflows (len <= count).
// TESTING
//  1 ch0 addr=0x000 count=200, MRRS_W=64 -> rq_len 64,64,64,8 at addr 0,64,128,192; tags 0,1,2,3;
//    r_ready[0] high again after last accept.
//  2 ch4 addr=0x1F0 count=40 -> rq_len 16 @0x1F0 then 24 @0x200 (4 KB split); irq once if flagged.
//  3 ch0 and ch4 both busy (count=128 each) -> grants alternate 0,4,0,4; rq_ready low 5 cycles
//    holds rq_* stable.
//  4 NTAGS=2, no releases -> exactly 2 requests, then rq_valid stays 0; tag_release(1) -> next
//    request uses tag 1.
//  5 count=0 with interrupt=1 on ch0 -> no rq_valid, irq_valid pulse irq_ch=0; r_valid on ch1
//    (disabled) -> ignored.
//  6 reset=0 during ISSUE -> rq_valid 0 next cycle, r_ready=ENABLES, first post-reset tag is 0.

Source files
------------

// File: rtl/hififo_read_scheduler_if.sv
// Read-request bus from the scheduler to the TLP transmit unit.
// rq_valid/rq_ready handshake; addr, len, tag and channel travel with it.
interface hififo_read_scheduler_if;
  logic        rq_valid;
  logic        rq_ready;
  logic [60:0] rq_addr;
  logic [6:0]  rq_len;
  logic [4:0]  rq_tag;
  logic [2:0]  rq_ch;

  modport master (
    output rq_valid, rq_addr, rq_len, rq_tag, rq_ch,
    input  rq_ready
  );

  modport slave (
    input  rq_valid, rq_addr, rq_len, rq_tag, rq_ch,
    output rq_ready
  );
endinterface

// File: rtl/hififo_read_scheduler.sv
// Round-robin PCIe read scheduler: splits per-channel descriptors into
// MRRS/4KB-bounded requests with pooled tags.
// Ports: clock, reset (sync, active-low); r_* descriptor load, r_ready;
// rq (master) request bus; tag_release/tag_rel_id; irq_valid/irq_ch.
module hififo_read_scheduler #(
  parameter logic [7:0]  ENABLES = 8'b00010001,
  parameter int unsigned MRRS_W  = 64,
  parameter int unsigned NTAGS   = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  r_valid,
  input  logic [60:0] r_addr,
  input  logic [18:0] r_count,
  input  logic        r_interrupt,
  output logic [7:0]  r_ready,
  hififo_read_scheduler_if.master rq,
  input  logic        tag_release,
  input  logic [4:0]  tag_rel_id,
  output logic        irq_valid,
  output logic [2:0]  irq_ch
);

  localparam logic [0:0] ARB   = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  // Tags at or above NTAGS start busy and can never be released.
  localparam logic [31:0] TAG_INIT =
    32'((64'd1 << NTAGS) - 64'd1);

  logic [0:0]  state_q;
  logic [2:0]  rr_q;
  logic [7:0]  busy_q;
  logic [7:0]  int_q;
  logic [60:0] addr_q [8];
  logic [18:0] cnt_q [8];
  logic [31:0] free_q;

  logic [60:0] rq_addr_q;
  logic [6:0]  rq_len_q;
  logic [4:0]  rq_tag_q;
  logic [2:0]  rq_ch_q;
  logic        irq_valid_q;
  logic [2:0]  irq_ch_q;

  logic [7:0]  elig;
  logic [7:0]  zero;
  logic        gnt_ok;
  logic [2:0]  gnt_ch;
  logic [2:0]  idx;
  logic        zero_ok;
  logic [2:0]  zero_ch;
  logic [4:0]  tag_sel;
  logic [9:0]  room;
  logic [6:0]  len_d;
  logic        acc_done;

  always_comb begin
    elig = '0;
    zero = '0;
    for (int i = 0; i < 8; i++) begin
      elig[i] = ENABLES[i] & busy_q[i] & (cnt_q[i] != '0);
      zero[i] = busy_q[i] & (cnt_q[i] == '0);
    end

    // Scan downward so the nearest channel at/after rr_q wins.
    gnt_ok = |elig;
    gnt_ch = '0;
    idx    = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = rr_q + 3'(k);
      if (elig[idx]) gnt_ch = idx;
    end

    zero_ok = |zero;
    zero_ch = '0;
    for (int i = 7; i >= 0; i--) begin
      if (zero[i]) zero_ch = 3'(i);
    end

    tag_sel = '0;
    for (int t = 31; t >= 0; t--) begin
      if (free_q[t]) tag_sel = 5'(t);
    end

    // Words left before the next 4 KB (512-word) boundary.
    room  = 10'd512 - {1'b0, addr_q[gnt_ch][8:0]};
    len_d = (cnt_q[gnt_ch] < 19'(MRRS_W)) ?
            cnt_q[gnt_ch][6:0] : 7'(MRRS_W);
    if ({3'b0, len_d} > room) len_d = room[6:0];

    acc_done = (state_q == ISSUE) & rq.rq_ready &
               (cnt_q[rq_ch_q] == {12'd0, rq_len_q});
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ARB;
      rr_q        <= '0;
      busy_q      <= '0;
      int_q       <= '0;
      free_q      <= TAG_INIT;
      rq_addr_q   <= '0;
      rq_len_q    <= '0;
      rq_tag_q    <= '0;
      rq_ch_q     <= '0;
      irq_valid_q <= 1'b0;
      irq_ch_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      irq_valid_q <= 1'b0;

      for (int i = 0; i < 8; i++) begin
        if (r_valid[i] && ENABLES[i] && !busy_q[i]) begin
          busy_q[i] <= 1'b1;
          addr_q[i] <= r_addr;
          cnt_q[i]  <= r_count;
          int_q[i]  <= r_interrupt;
        end
      end

      if (tag_release && (32'(tag_rel_id) < NTAGS))
        free_q[tag_rel_id] <= 1'b1;

      if (state_q == ISSUE) begin
        if (rq.rq_ready) begin
          addr_q[rq_ch_q] <= addr_q[rq_ch_q] + 61'(rq_len_q);
          cnt_q[rq_ch_q]  <= cnt_q[rq_ch_q] - 19'(rq_len_q);
          rr_q            <= rq_ch_q + 3'd1;
          state_q         <= ARB;
          if (acc_done) begin
            busy_q[rq_ch_q] <= 1'b0;
            irq_valid_q     <= int_q[rq_ch_q];
            irq_ch_q        <= rq_ch_q;
          end
        end
      end else if (gnt_ok && (free_q != '0)) begin
        // Grant after release so a tag granted now stays busy.
        rq_addr_q       <= addr_q[gnt_ch];
        rq_len_q        <= len_d;
        rq_tag_q        <= tag_sel;
        rq_ch_q         <= gnt_ch;
        free_q[tag_sel] <= 1'b0;
        state_q         <= ISSUE;
      end

      // Empty descriptors retire here; an accept finishing a
      // descriptor owns the irq port this cycle, so defer.
      if (zero_ok && !acc_done) begin
        busy_q[zero_ch] <= 1'b0;
        irq_valid_q     <= int_q[zero_ch];
        irq_ch_q        <= zero_ch;
      end
    end
  end

  assign r_ready     = ENABLES & ~busy_q;
  assign rq.rq_valid = (state_q == ISSUE);
  assign rq.rq_addr  = rq_addr_q;
  assign rq.rq_len   = rq_len_q;
  assign rq.rq_tag   = rq_tag_q;
  assign rq.rq_ch    = rq_ch_q;
  assign irq_valid   = irq_valid_q;
  assign irq_ch      = irq_ch_q;

endmodule

// File: tb/tb_hififo_read_scheduler.sv
// Testbench for hififo_read_scheduler: directed vector table,
// multi-cycle corner sequences, then randomized traffic vs a model.
module tb_hififo_read_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  r_valid = '0;
  logic [60:0] r_addr = '0;
  logic [18:0] r_count = '0;
  logic        r_interrupt = 1'b0;
  logic [7:0]  r_ready;
  logic        tag_release = 1'b0;
  logic [4:0]  tag_rel_id = '0;
  logic        irq_valid;
  logic [2:0]  irq_ch;

  hififo_read_scheduler_if rq ();

  hififo_read_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .r_valid     (r_valid),
    .r_addr      (r_addr),
    .r_count     (r_count),
    .r_interrupt (r_interrupt),
    .r_ready     (r_ready),
    .rq          (rq),
    .tag_release (tag_release),
    .tag_rel_id  (tag_rel_id),
    .irq_valid   (irq_valid),
    .irq_ch      (irq_ch)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (rq.rq_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b0;
    r_valid     = '0;
    rq.rq_ready = 1'b0;
    tag_release = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic load(input logic [7:0] v, input logic [60:0] a,
                      input logic [18:0] c, input bit in);
    @(negedge clock);
    r_valid     = v;
    r_addr      = a;
    r_count     = c;
    r_interrupt = in;
    @(negedge clock);
    r_valid = '0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [60:0] a;
    logic [6:0]  l;
    bit          irq;
  } chunk_t;

  chunk_t chq [8][$];
  bit     tag_busy [32];
  int     outq [$];
  bit     mon_en = 1'b0;
  bit     pend_prev = 1'b0;
  logic [60:0] pa;
  logic [6:0]  pl;
  logic [4:0]  pt;
  logic [2:0]  pc;
  bit          irq_exp = 1'b0;
  logic [2:0]  irq_exp_ch = '0;
  int          m_c;
  chunk_t      m_e;

  // Expected request list: greedy chunks bounded by 64 words and
  // by the distance to the next 512-word page.
  function automatic void push_desc(input int ch, input logic [60:0] a,
                                    input logic [18:0] c, input bit in);
    logic [60:0] aa;
    int rem;
    int room;
    int l;
    chunk_t e;
    aa  = a;
    rem = int'(c);
    while (rem > 0) begin
      room = 512 - int'(aa % 61'd512);
      l = rem;
      if (l > 64) l = 64;
      if (l > room) l = room;
      e.a   = aa;
      e.l   = 7'(l);
      e.irq = in && (rem == l);
      chq[ch].push_back(e);
      aa  = aa + 61'(l);
      rem = rem - l;
    end
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      chk("rnd_irq_valid", 64'(irq_valid), 64'(irq_exp));
      if (irq_exp && irq_valid)
        chk("rnd_irq_ch", 64'(irq_ch), 64'(irq_exp_ch));
      irq_exp = 1'b0;
      if (pend_prev) begin
        chk("rnd_hold_valid", 64'(rq.rq_valid), 64'd1);
        chk("rnd_hold_addr", 64'(rq.rq_addr), 64'(pa));
        chk("rnd_hold_ltc", 64'({rq.rq_len, rq.rq_tag, rq.rq_ch}),
            64'({pl, pt, pc}));
      end
      if (rq.rq_valid && rq.rq_ready) begin
        m_c = int'(rq.rq_ch);
        chk("rnd_req_expected", 64'(chq[m_c].size() > 0), 64'd1);
        if (chq[m_c].size() > 0) begin
          m_e = chq[m_c].pop_front();
          chk("rnd_addr", 64'(rq.rq_addr), 64'(m_e.a));
          chk("rnd_len", 64'(rq.rq_len), 64'(m_e.l));
          chk("rnd_tag_free", 64'(tag_busy[rq.rq_tag]), 64'd0);
          tag_busy[rq.rq_tag] = 1'b1;
          outq.push_back(int'(rq.rq_tag));
          irq_exp    = m_e.irq;
          irq_exp_ch = rq.rq_ch;
        end
      end
      pend_prev = rq.rq_valid && !rq.rq_ready;
      pa = rq.rq_addr;
      pl = rq.rq_len;
      pt = rq.rq_tag;
      pc = rq.rq_ch;
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]        ch;
    logic [60:0]       addr;
    logic [18:0]       cnt;
    bit                intr;
    int                n;
    logic [3:0][60:0]  ea;
    logic [3:0][6:0]   el;
  } vec_t;

  vec_t vt [5];
  bit   ok;
  logic [60:0] sa;
  logic [14:0] sltc;
  int   cnt_irq;
  int   cnt_rq;
  logic [2:0] last_irq_ch;
  int   rch;
  int   rk;
  logic [60:0] ra;
  logic [18:0] rc;
  bit   rin;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    vt[0].ch = 3'd0; vt[0].addr = 61'h0; vt[0].cnt = 19'd200;
    vt[0].intr = 1'b0; vt[0].n = 4;
    vt[0].ea = {61'd192, 61'd128, 61'd64, 61'd0};
    vt[0].el = {7'd8, 7'd64, 7'd64, 7'd64};

    vt[1].ch = 3'd4; vt[1].addr = 61'h1F0; vt[1].cnt = 19'd40;
    vt[1].intr = 1'b1; vt[1].n = 2;
    vt[1].ea = {61'd0, 61'd0, 61'h200, 61'h1F0};
    vt[1].el = {7'd0, 7'd0, 7'd24, 7'd16};

    vt[2].ch = 3'd0; vt[2].addr = 61'h1FF; vt[2].cnt = 19'd3;
    vt[2].intr = 1'b1; vt[2].n = 2;
    vt[2].ea = {61'd0, 61'd0, 61'h200, 61'h1FF};
    vt[2].el = {7'd0, 7'd0, 7'd2, 7'd1};

    vt[3].ch = 3'd4; vt[3].addr = 61'h1C0; vt[3].cnt = 19'd64;
    vt[3].intr = 1'b0; vt[3].n = 1;
    vt[3].ea = {61'd0, 61'd0, 61'd0, 61'h1C0};
    vt[3].el = {7'd0, 7'd0, 7'd0, 7'd64};

    vt[4].ch = 3'd0; vt[4].addr = 61'h1FFF_FFFF_FFFF_FFFE;
    vt[4].cnt = 19'd4; vt[4].intr = 1'b1; vt[4].n = 2;
    vt[4].ea = {61'd0, 61'd0, 61'd0, 61'h1FFF_FFFF_FFFF_FFFE};
    vt[4].el = {7'd0, 7'd0, 7'd2, 7'd2};

    rq.rq_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_rq_valid", 64'(rq.rq_valid), 64'd0);
    chk("rst_r_ready", 64'(r_ready), 64'h11);
    chk("rst_irq_valid", 64'(irq_valid), 64'd0);
    chk("rst_rq_fields", 64'({rq.rq_len, rq.rq_tag, rq.rq_ch}), 64'd0);
    chk("rst_rq_addr", 64'(rq.rq_addr), 64'd0);
    reset = 1'b1;

    // Chunking table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      rq.rq_ready = 1'b1;
      load(8'd1 << vt[v].ch, vt[v].addr, vt[v].cnt, vt[v].intr);
      for (int k = 0; k < vt[v].n; k++) begin
        wait_valid(20, ok);
        chk($sformatf("v%0d_r%0d_seen", v, k), 64'(ok), 64'd1);
        chk($sformatf("v%0d_r%0d_addr", v, k),
            64'(rq.rq_addr), 64'(vt[v].ea[k]));
        chk($sformatf("v%0d_r%0d_len", v, k),
            64'(rq.rq_len), 64'(vt[v].el[k]));
        chk($sformatf("v%0d_r%0d_tag", v, k), 64'(rq.rq_tag), 64'(k));
        chk($sformatf("v%0d_r%0d_ch", v, k), 64'(rq.rq_ch), 64'(vt[v].ch));
        chk($sformatf("v%0d_r%0d_busy", v, k),
            64'(r_ready[vt[v].ch]), 64'd0);
      end
      @(negedge clock);
      chk($sformatf("v%0d_irq", v), 64'(irq_valid), 64'(vt[v].intr));
      if (vt[v].intr)
        chk($sformatf("v%0d_irq_ch", v), 64'(irq_ch), 64'(vt[v].ch));
      chk($sformatf("v%0d_ready", v), 64'(r_ready), 64'h11);
      wait_valid(8, ok);
      chk($sformatf("v%0d_no_extra", v), 64'(ok), 64'd0);
    end

    // Alternation and stall hold
    do_reset();
    rq.rq_ready = 1'b0;
    load(8'h11, 61'h0, 19'd128, 1'b0);
    wait_valid(20, ok);
    chk("alt_first_seen", 64'(ok), 64'd1);
    sa   = rq.rq_addr;
    sltc = {rq.rq_len, rq.rq_tag, rq.rq_ch};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("stall%0d_valid", i), 64'(rq.rq_valid), 64'd1);
      chk($sformatf("stall%0d_addr", i), 64'(rq.rq_addr), 64'(sa));
      chk($sformatf("stall%0d_ltc", i),
          64'({rq.rq_len, rq.rq_tag, rq.rq_ch}), 64'(sltc));
    end
    chk("alt0_ch", 64'(rq.rq_ch), 64'd0);
    chk("alt0_tag", 64'(rq.rq_tag), 64'd0);
    rq.rq_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      wait_valid(20, ok);
      chk($sformatf("alt%0d_seen", k), 64'(ok), 64'd1);
      chk($sformatf("alt%0d_ch", k), 64'(rq.rq_ch), (k % 2 == 1) ? 64'd4 : 64'd0);
      chk($sformatf("alt%0d_addr", k), 64'(rq.rq_addr), (k >= 2) ? 64'd64 : 64'd0);
      chk($sformatf("alt%0d_tag", k), 64'(rq.rq_tag), 64'(k));
    end

    // Tag exhaustion and release
    do_reset();
    rq.rq_ready = 1'b1;
    load(8'h01, 61'h0, 19'd2560, 1'b0);
    for (int k = 0; k < 32; k++) begin
      wait_valid(20, ok);
      chk($sformatf("tags%0d_seen", k), 64'(ok), 64'd1);
      chk($sformatf("tags%0d_tag", k), 64'(rq.rq_tag), 64'(k));
    end
    wait_valid(20, ok);
    chk("tags_exhausted", 64'(ok), 64'd0);
    tag_release = 1'b1;
    tag_rel_id  = 5'd1;
    @(negedge clock);
    tag_release = 1'b0;
    wait_valid(20, ok);
    chk("tags_rel_seen", 64'(ok), 64'd1);
    chk("tags_rel_tag", 64'(rq.rq_tag), 64'd1);
    chk("tags_rel_addr", 64'(rq.rq_addr), 64'd2048);

    // Zero-count descriptor with interrupt, disabled channel ignored
    do_reset();
    rq.rq_ready = 1'b1;
    load(8'h03, 61'h40, 19'd0, 1'b1);
    cnt_irq = 0;
    cnt_rq  = 0;
    last_irq_ch = 3'd7;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (irq_valid) begin
        cnt_irq++;
        last_irq_ch = irq_ch;
      end
      if (rq.rq_valid) cnt_rq++;
    end
    chk("zero_irq_count", 64'(cnt_irq), 64'd1);
    chk("zero_irq_ch", 64'(last_irq_ch), 64'd0);
    chk("zero_no_req", 64'(cnt_rq), 64'd0);
    chk("zero_ready", 64'(r_ready), 64'h11);

    // Reset during ISSUE
    do_reset();
    rq.rq_ready = 1'b0;
    load(8'h01, 61'h100, 19'd16, 1'b0);
    wait_valid(20, ok);
    chk("mrst_issue_seen", 64'(ok), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("mrst_valid", 64'(rq.rq_valid), 64'd0);
    chk("mrst_ready", 64'(r_ready), 64'h11);
    reset = 1'b1;
    rq.rq_ready = 1'b1;
    load(8'h10, 61'h40, 19'd8, 1'b0);
    wait_valid(20, ok);
    chk("mrst_post_seen", 64'(ok), 64'd1);
    chk("mrst_post_tag", 64'(rq.rq_tag), 64'd0);
    chk("mrst_post_ch", 64'(rq.rq_ch), 64'd4);
    chk("mrst_post_len", 64'(rq.rq_len), 64'd8);
    wait_valid(10, ok);
    chk("mrst_discarded", 64'(ok), 64'd0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 8; c++) chq[c].delete();
    for (int t = 0; t < 32; t++) tag_busy[t] = 1'b0;
    outq.delete();
    pend_prev = 1'b0;
    irq_exp   = 1'b0;
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clock);
      #1;
      r_valid     = '0;
      tag_release = 1'b0;
      rq.rq_ready = ($urandom_range(3) != 0);
      rch = ($urandom_range(1) != 0) ? 4 : 0;
      if (r_ready[rch] && $urandom_range(4) == 0) begin
        ra = 61'({$urandom, $urandom});
        if ($urandom_range(1) != 0) ra[8:0] = 9'h1F0 + 9'($urandom_range(15));
        rc  = 19'($urandom_range(300, 1));
        rin = ($urandom_range(1) != 0);
        r_valid     = 8'd1 << rch;
        r_addr      = ra;
        r_count     = rc;
        r_interrupt = rin;
        push_desc(rch, ra, rc, rin);
      end
      if (outq.size() > 0 && $urandom_range(2) == 0) begin
        rk = $urandom_range(outq.size() - 1);
        tag_rel_id  = 5'(outq[rk]);
        tag_release = 1'b1;
        tag_busy[outq[rk]] = 1'b0;
        outq.delete(rk);
      end
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clock);
      #1;
      r_valid     = '0;
      tag_release = 1'b0;
      rq.rq_ready = 1'b1;
      if (outq.size() > 0) begin
        tag_rel_id  = 5'(outq[0]);
        tag_release = 1'b1;
        tag_busy[outq[0]] = 1'b0;
        void'(outq.pop_front());
      end
      if (chq[0].size() == 0 && chq[4].size() == 0 && !rq.rq_valid) break;
    end
    repeat (4) @(posedge clock);
    #1;
    mon_en = 1'b0;
    chk("drain_ch0", 64'(chq[0].size()), 64'd0);
    chk("drain_ch4", 64'(chq[4].size()), 64'd0);
    chk("drain_ready", 64'(r_ready), 64'h11);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
